sobel_frame_loader: RTL

- Upstream feeder for the sobel core.
- Accepts a raster-order 8-bit pixel stream over a valid/ready handshake and writes each pixel into the shared input frame RAM through its write port, using the sobel {Y,X} address format.
- After a complete frame, starts the sobel core with the ap_start/ap_done handshake and holds off the next frame until the core reports done.
- Tracks frame-length errors and a completed-frame count.

---
 rtl/sobel_frame_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sobel_frame_loader.sv
// sobel_frame_loader
//   Upstream feeder for the sobel core. Takes a raster-order pixel stream over
//   a valid/ready handshake, writes every accepted pixel straight into the
//   shared input frame RAM at address {row,col}, and once a full frame has
//   landed it starts the sobel core and waits for it to finish before taking
//   the next frame. ADDR_W must equal ROW_BITS+COL_BITS.
//
//   Ports:
//     ap_clk, ap_rst_n      clock, async active-low reset
//     enable                permits starting a new frame fill
//     s_valid/s_ready       pixel handshake; s_data pixel, s_last frame end
//     indata_*1             RAM write port (combinational with the accept)
//     sobel_ap_start/done   sobel core start/done handshake
//     frame_done            one-cycle pulse per completed sobel run
//     err_len               sticky frame-length error
//     frame_cnt             completed frame count (wraps)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for enable, stream stalled
//   FILL  | accepting pixels and writing them to the frame RAM
//   RUN   | sobel core running on the frame, stream stalled until done
module sobel_frame_loader #(
  parameter int COL_BITS = 9,
  parameter int ROW_BITS = 9,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] indata_address1,
  output logic              indata_ce1,
  output logic              indata_we1,
  output logic [DATA_W-1:0] indata_d1,
  output logic              sobel_ap_start,
  input  logic              sobel_ap_done,
  output logic              frame_done,
  output logic              err_len,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [COL_BITS-1:0] COL_MAX = '1;
  localparam logic [ROW_BITS-1:0] ROW_MAX = '1;
  localparam logic [COL_BITS-1:0] COL_ONE = 1;
  localparam logic [ROW_BITS-1:0] ROW_ONE = 1;

  state_t              state, state_next;
  logic [COL_BITS-1:0] col, col_next;
  logic [ROW_BITS-1:0] row, row_next;
  logic                start_next, done_next, err_next;
  logic [15:0]         cnt_next;
  logic                accept, last_pos;

  assign s_ready  = (state == FILL);
  assign accept   = s_valid & s_ready;
  assign last_pos = (row == ROW_MAX) && (col == COL_MAX);

  // Write port follows the accept in the same cycle; the address is just the
  // live counters, which sit at zero whenever no frame is in progress.
  assign indata_ce1      = accept;
  assign indata_we1      = accept;
  assign indata_address1 = {row, col};
  assign indata_d1       = accept ? s_data : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      sobel_ap_start <= 1'b0;
      frame_done     <= 1'b0;
      err_len        <= 1'b0;
      frame_cnt      <= 16'd0;
    end else begin
      state          <= state_next;
      col            <= col_next;
      row            <= row_next;
      sobel_ap_start <= start_next;
      frame_done     <= done_next;
      err_len        <= err_next;
      frame_cnt      <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    start_next = sobel_ap_start;
    done_next  = 1'b0;
    err_next   = err_len;
    cnt_next   = frame_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = FILL;
          col_next   = '0;
          row_next   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (last_pos) begin
            // Full frame in RAM: s_last only flags a mismatch, it never
            // stops the core from being started on a complete frame.
            state_next = RUN;
            col_next   = '0;
            row_next   = '0;
            start_next = 1'b1;
            if (!s_last) err_next = 1'b1;
          end else if (s_last) begin
            // Short frame: drop it and start over at address 0.
            err_next = 1'b1;
            col_next = '0;
            row_next = '0;
          end else if (col == COL_MAX) begin
            col_next = '0;
            row_next = row + ROW_ONE;
          end else begin
            col_next = col + COL_ONE;
          end
        end
      end
      RUN: begin
        if (sobel_ap_done) begin
          start_next = 1'b0;
          done_next  = 1'b1;
          cnt_next   = frame_cnt + 16'd1;
          state_next = enable ? FILL : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
